// File: rtl/checkpoint_checker_if.sv
// Bus bundle between a stimulus/observation source and checkpoint_checker.
// The checker side uses the slave modport; the driving side uses master.
interface checkpoint_checker_if #(
    parameter int IDX_W = 2,
    parameter int CYC_W = 10
);
    logic [7:0]       obs_a;
    logic [7:0]       obs_b;
    logic [7:0]       obs_c;
    logic [7:0]       obs_d;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [CYC_W-1:0] cfg_cycle;
    logic [31:0]      cfg_exp;
    logic [3:0]       cfg_mask;
    logic [IDX_W:0]   cfg_num;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [7:0]       err_cnt;
    logic [3:0]       mis_flags;
    logic [IDX_W:0]   chk_idx;
    logic [1:0]       state;

    // Control is a plain strobe protocol: cfg_we writes one entry per cycle
    // outside RUN, start is a single-cycle request honoured in IDLE/DONE only.
    modport master (
        output obs_a, obs_b, obs_c, obs_d,
        output cfg_we, cfg_idx, cfg_cycle, cfg_exp, cfg_mask, cfg_num, start,
        input  busy, done, pass, timeout, err_cnt, mis_flags, chk_idx, state
    );

    modport slave (
        input  obs_a, obs_b, obs_c, obs_d,
        input  cfg_we, cfg_idx, cfg_cycle, cfg_exp, cfg_mask, cfg_num, start,
        output busy, done, pass, timeout, err_cnt, mis_flags, chk_idx, state
    );
endinterface

// File: rtl/checkpoint_checker.sv
// Hardware result checker: compares four observed bytes against a loaded
// table of (cycle, expected, mask) checkpoints and reports a run verdict.
module checkpoint_checker #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CYC_W = 10
) (
    input logic                 clk,
    input logic                 rst,
    checkpoint_checker_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CYC_W-1:0] CYC_MAX = '1;
    localparam logic [IDX_W:0]   NUM_MAX = (IDX_W+1)'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;

    logic [CYC_W-1:0] r_tbl_cycle [DEPTH];
    logic [31:0]      r_tbl_exp   [DEPTH];
    logic [3:0]       r_tbl_mask  [DEPTH];

    logic [IDX_W:0]   r_num;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic [IDX_W:0]   r_chk_idx;
    logic [7:0]       r_err_cnt;
    logic [3:0]       r_mis_flags;
    logic             r_timeout;

    logic [IDX_W-1:0] w_entry;
    logic [IDX_W:0]   w_idx_inc;
    logic             w_pending;
    logic             w_match;
    logic             w_last;
    logic             w_timeout;
    logic [31:0]      w_obs;
    logic [31:0]      w_exp;
    logic [3:0]       w_diff;
    logic [2:0]       w_diff_cnt;
    logic [8:0]       w_err_sum;
    logic [7:0]       w_err_next;
    logic [IDX_W:0]   w_num_clamped;

    // Table has no reset so its contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && (r_state != S_RUN)) begin
            r_tbl_cycle[bus.cfg_idx] <= bus.cfg_cycle;
            r_tbl_exp[bus.cfg_idx]   <= bus.cfg_exp;
            r_tbl_mask[bus.cfg_idx]  <= bus.cfg_mask;
        end
    end

    assign w_entry    = r_chk_idx[IDX_W-1:0];
    assign w_idx_inc  = r_chk_idx + {{IDX_W{1'b0}}, 1'b1};
    assign w_pending  = (r_chk_idx < r_num);
    assign w_match    = (r_state == S_RUN) && w_pending && (r_cyc_cnt == r_tbl_cycle[w_entry]);
    assign w_last     = w_match && (w_idx_inc == r_num);
    // Any unfinished table at the final count ends the run, even if a
    // non-final entry matched in that same cycle.
    assign w_timeout  = (r_state == S_RUN) && w_pending && (r_cyc_cnt == CYC_MAX) && !w_last;

    assign w_obs      = {bus.obs_a, bus.obs_b, bus.obs_c, bus.obs_d};
    assign w_exp      = r_tbl_exp[w_entry];
    assign w_diff[3]  = r_tbl_mask[w_entry][3] && (w_obs[31:24] != w_exp[31:24]);
    assign w_diff[2]  = r_tbl_mask[w_entry][2] && (w_obs[23:16] != w_exp[23:16]);
    assign w_diff[1]  = r_tbl_mask[w_entry][1] && (w_obs[15:8]  != w_exp[15:8]);
    assign w_diff[0]  = r_tbl_mask[w_entry][0] && (w_obs[7:0]   != w_exp[7:0]);
    assign w_diff_cnt = 3'(w_diff[3]) + 3'(w_diff[2]) + 3'(w_diff[1]) + 3'(w_diff[0]);
    assign w_err_sum  = {1'b0, r_err_cnt} + {6'd0, w_diff_cnt};
    assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    assign w_num_clamped = (bus.cfg_num > NUM_MAX) ? NUM_MAX : bus.cfg_num;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next   = S_RUN;
                    w_accept = 1'b1;
                end
            end
            S_RUN: begin
                if (!w_pending || w_last || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num       <= '0;
            r_cyc_cnt   <= '0;
            r_chk_idx   <= '0;
            r_err_cnt   <= '0;
            r_mis_flags <= '0;
            r_timeout   <= 1'b0;
        end else if (w_accept) begin
            r_num       <= w_num_clamped;
            r_cyc_cnt   <= '0;
            r_chk_idx   <= '0;
            r_err_cnt   <= '0;
            r_mis_flags <= '0;
            r_timeout   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cyc_cnt <= r_cyc_cnt + {{(CYC_W-1){1'b0}}, 1'b1};
            if (w_match) begin
                r_chk_idx   <= w_idx_inc;
                r_err_cnt   <= w_err_next;
                r_mis_flags <= r_mis_flags | w_diff;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pass      = (r_state == S_DONE) && (r_err_cnt == 8'd0) && !r_timeout;
    assign bus.timeout   = r_timeout;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.mis_flags = r_mis_flags;
    assign bus.chk_idx   = r_chk_idx;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_checkpoint_checker.sv
// Self-checking bench for checkpoint_checker: directed scenarios plus
// randomized tables, checked against a table-walking reference model.
module tb_checkpoint_checker;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int CYC_W = 10;
    localparam int NCYC  = 1 << CYC_W;

    logic clk;
    logic rst;

    checkpoint_checker_if #(.IDX_W(IDX_W), .CYC_W(CYC_W)) bus ();

    checkpoint_checker #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CYC_W(CYC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          m_cycle [DEPTH];
    logic [31:0] m_exp   [DEPTH];
    logic [3:0]  m_mask  [DEPTH];
    logic [31:0] plan    [NCYC];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic drive_obs(input logic [31:0] v);
        bus.obs_a = v[31:24];
        bus.obs_b = v[23:16];
        bus.obs_c = v[15:8];
        bus.obs_d = v[7:0];
    endtask

    task automatic set_entry(input int idx, input int cyc, input logic [31:0] exp, input logic [3:0] mask);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = IDX_W'(idx);
        bus.cfg_cycle = CYC_W'(cyc);
        bus.cfg_exp   = exp;
        bus.cfg_mask  = mask;
        m_cycle[idx]  = cyc;
        m_exp[idx]    = exp;
        m_mask[idx]   = mask;
    endtask

    // Called right after a negedge; returns right after the next one.
    task automatic write_entry(input int idx, input int cyc, input logic [31:0] exp, input logic [3:0] mask);
        set_entry(idx, cyc, exp, mask);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic fill_plan_random();
        for (int c = 0; c < NCYC; c++) plan[c] = $urandom;
    endtask

    // Walk the active entries: each is reached only if its cycle lies beyond the
    // previously matched one; the first unreachable entry means a timeout.
    task automatic predict(input int num, output int e_err, output logic [3:0] e_mis,
                           output bit e_to, output int e_idx, output int e_cyc);
        int n;
        int prev;
        logic [3:0] d;
        n = (num > DEPTH) ? DEPTH : num;
        e_err = 0; e_mis = 4'd0; e_to = 1'b0; e_idx = n; prev = -1;
        for (int k = 0; k < n; k++) begin
            if (m_cycle[k] > prev) begin
                for (int ch = 0; ch < 4; ch++)
                    d[ch] = m_mask[k][ch] && (plan[m_cycle[k]][8*ch +: 8] != m_exp[k][8*ch +: 8]);
                e_mis = e_mis | d;
                e_err = e_err + $countones(d);
                prev  = m_cycle[k];
            end else begin
                e_to  = 1'b1;
                e_idx = k;
                break;
            end
        end
        if (e_err > 255) e_err = 255;
        e_cyc = e_to ? NCYC : ((n == 0) ? 1 : prev + 1);
    endtask

    task automatic do_run(input string tag, input int num, input bit stray, input bit wr_start,
                          input int wr_idx, input int wr_cyc, input logic [31:0] wr_exp,
                          input logic [3:0] wr_mask);
        int e_err, e_idx, e_cyc, cyc;
        logic [3:0] e_mis;
        bit e_to;
        bus.cfg_num = (IDX_W+1)'(num);
        bus.start   = 1'b1;
        if (wr_start) set_entry(wr_idx, wr_cyc, wr_exp, wr_mask);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        predict(num, e_err, e_mis, e_to, e_idx, e_cyc);
        check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (bus.busy && cyc < NCYC + 64) begin
            drive_obs((cyc < NCYC) ? plan[cyc] : 32'd0);
            if (stray && cyc == 5) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_idx   = IDX_W'($urandom);
                bus.cfg_cycle = CYC_W'($urandom);
                bus.cfg_exp   = $urandom;
                bus.cfg_mask  = 4'hF;
            end else begin
                bus.cfg_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cfg_we = 1'b0;
        check_val({tag, "_cycles"}, 32'(cyc), 32'(e_cyc));
        check_val({tag, "_done"}, 32'(bus.done), 32'd1);
        check_val({tag, "_pass"}, 32'(bus.pass), 32'((e_err == 0) && !e_to));
        check_val({tag, "_err"}, 32'(bus.err_cnt), 32'(e_err));
        check_val({tag, "_mis"}, 32'(bus.mis_flags), 32'(e_mis));
        check_val({tag, "_timeout"}, 32'(bus.timeout), 32'(e_to));
        check_val({tag, "_chk_idx"}, 32'(bus.chk_idx), 32'(e_idx));
        repeat (3) begin
            drive_obs($urandom);
            @(negedge clk);
        end
        check_val({tag, "_hold_done"}, 32'(bus.done), 32'd1);
        check_val({tag, "_hold_err"}, 32'(bus.err_cnt), 32'(e_err));
        check_val({tag, "_hold_mis"}, 32'(bus.mis_flags), 32'(e_mis));
        check_val({tag, "_hold_pass"}, 32'(bus.pass), 32'((e_err == 0) && !e_to));
    endtask

    task automatic load_base_table();
        write_entry(0, 49, {8'd48, 8'd0, 8'd0, 8'd0}, 4'hF);
        write_entry(1, 88, {8'd48, 8'd39, 8'd38, 8'd0}, 4'hF);
        fill_plan_random();
        plan[49] = {8'd48, 8'd0, 8'd0, 8'd0};
        plan[88] = {8'd48, 8'd39, 8'd38, 8'd0};
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_cycle = '0; bus.cfg_exp = '0;
        bus.cfg_mask = '0; bus.cfg_num = '0; bus.start = 1'b0;
        drive_obs(32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            m_cycle[k] = 0; m_exp[k] = '0; m_mask[k] = '0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_pass", 32'(bus.pass), 32'd0);
        check_val("rst_timeout", 32'(bus.timeout), 32'd0);
        check_val("rst_err", 32'(bus.err_cnt), 32'd0);
        check_val("rst_mis", 32'(bus.mis_flags), 32'd0);
        check_val("rst_chk_idx", 32'(bus.chk_idx), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < DEPTH; k++) write_entry(k, 1000, 32'd0, 4'hF);
        load_base_table();
        do_run("match", 2, 1'b0, 1'b0, 0, 0, 0, 0);

        plan[88] = {8'd48, 8'd40, 8'd38, 8'd0};
        do_run("b_miss", 2, 1'b0, 1'b0, 0, 0, 0, 0);

        write_entry(1, 88, {8'd48, 8'd39, 8'd38, 8'd0}, 4'b1101);
        plan[88] = {8'd48, 8'd39, 8'd5, 8'd1};
        do_run("masked", 2, 1'b0, 1'b0, 0, 0, 0, 0);

        do_run("num0", 0, 1'b0, 1'b0, 0, 0, 0, 0);

        write_entry(0, 20, 32'h01020304, 4'hF);
        write_entry(1, 10, 32'h05060708, 4'hF);
        plan[20] = 32'h01020304;
        plan[10] = 32'h05060708;
        do_run("order_to", 2, 1'b0, 1'b0, 0, 0, 0, 0);

        for (int k = 0; k < DEPTH; k++) begin
            write_entry(k, 100 + 50 * k, $urandom, 4'hF);
            plan[100 + 50 * k] = ~m_exp[k];
        end
        do_run("all_bad", 4, 1'b0, 1'b0, 0, 0, 0, 0);

        // Mid-run reset: errors accumulate, then reset clears outputs at once.
        write_entry(0, 10, 32'hA1B2C3D4, 4'hF);
        write_entry(1, 40, 32'h11223344, 4'hF);
        plan[10] = ~32'hA1B2C3D4;
        plan[40] = 32'h11223344;
        bus.cfg_num = 3'd2;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive_obs(plan[c]);
            @(negedge clk);
        end
        check_val("pre_rst_err", 32'(bus.err_cnt), 32'd4);
        #2 rst = 1'b0;
        #1;
        check_val("async_rst_busy", 32'(bus.busy), 32'd0);
        check_val("async_rst_err", 32'(bus.err_cnt), 32'd0);
        check_val("async_rst_mis", 32'(bus.mis_flags), 32'd0);
        check_val("async_rst_chk_idx", 32'(bus.chk_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        plan[10] = 32'hA1B2C3D4;
        do_run("reuse", 2, 1'b0, 1'b0, 0, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            int c;
            int num;
            bit ws;
            fill_plan_random();
            c = $urandom_range(0, 20);
            for (int k = 0; k < DEPTH; k++) begin
                if (k > 0 && $urandom_range(0, 99) < 8) c = c - $urandom_range(0, 5);
                if (c < 0) c = 0;
                ws = (k == DEPTH - 1) && $urandom_range(0, 1);
                if (!ws) write_entry(k, c, $urandom, 4'($urandom));
                else begin
                    m_cycle[k] = c; m_exp[k] = $urandom; m_mask[k] = 4'($urandom);
                end
                c = c + $urandom_range(1, 60);
            end
            for (int k = 0; k < DEPTH; k++) begin
                if ($urandom_range(0, 99) < 70) begin
                    plan[m_cycle[k]] = m_exp[k];
                    if ($urandom_range(0, 1)) plan[m_cycle[k]][8 * $urandom_range(0, 3) +: 8] ^= 8'h5A;
                end
            end
            num = $urandom_range(0, 7);
            do_run("rand", num, $urandom_range(0, 1), ws, DEPTH - 1,
                   m_cycle[DEPTH-1], m_exp[DEPTH-1], m_mask[DEPTH-1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
